ps2_key_ctrl: RTL and testbench

Scan-code controller between the PS/2 receiver and its consumers. It gates the receiver enable, decodes Set-2 prefix bytes (F0 = break, E0 = extended) into single key events, and buffers them in a small FIFO. Events are presented on a valid/ready port. It sits directly after the PS/2 receiver in `top`.

---
 rtl/ps2_key_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_ps2_key_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_ctrl.sv
// ps2_key_ctrl
//   Scan-code controller sitting after the PS/2 receiver. Folds Set-2 prefix
//   bytes (F0 = break, E0 = extended) into single key events, queues them in
//   a small FIFO and presents the head event on a valid/ready port.
//
//   Build option: define PS2_KEY_EXT_EN to build E0 (extended) handling.
//   Without it, E0 bytes are discarded, key_ext is 0 and entries are 9 bits.
//
// Ports
//   clk           system clock, rising edge
//   reset         asynchronous active-low reset
//   rx_done_tick  one-cycle strobe, rx_dout valid
//   rx_dout[7:0]  received byte
//   rx_en         receiver enable (FIFO has room)
//   key_code[7:0] scan code of head event
//   key_break     head event is a release
//   key_ext       head event had an E0 prefix
//   key_valid     FIFO not empty
//   key_ready     consumer accepts head event
//   overflow      sticky, an event was dropped
//   ovf_clr       clears overflow
//
// state   | meaning
// --------+-----------------------------------------------
// IDLE    | no prefix pending
// BRK     | F0 received, next code is a release
// EXT     | E0 received, next code is extended
// EXT_BRK | E0 F0 received, next code is an extended release

module ps2_key_ctrl #(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_done_tick,
    input  logic [7:0] rx_dout,
    output logic       rx_en,
    output logic [7:0] key_code,
    output logic       key_break,
    output logic       key_ext,
    output logic       key_valid,
    input  logic       key_ready,
    output logic       overflow,
    input  logic       ovf_clr
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = ($clog2(TIMEOUT) > 16) ? $clog2(TIMEOUT) : 16;
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);
    localparam logic [AW:0]   DEPTH_C = (AW+1)'(FIFO_DEPTH);

`ifdef PS2_KEY_EXT_EN
    localparam int EW = 10;
    typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;
`else
    localparam int EW = 9;
    typedef enum logic [0:0] {IDLE, BRK} state_t;
`endif

    state_t          state, state_nxt;
    logic [CW-1:0]   to_cnt;
    logic            to_hit;
    logic            push_req;
    logic [EW-1:0]   push_data;
    logic [EW-1:0]   mem [FIFO_DEPTH];
    logic [EW-1:0]   head;
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [AW:0]     count, count_nxt;
    logic            full, pop, push;

    // ---------------- prefix decoder ----------------
    assign to_hit = (state != IDLE) && (to_cnt == TO_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        push_req  = 1'b0;
        push_data = '0;
        if (rx_done_tick) begin
            case (rx_dout)
                8'h00, 8'hFF: state_nxt = IDLE;
`ifdef PS2_KEY_EXT_EN
                8'hE0: state_nxt = EXT;
                8'hF0: begin
                    case (state)
                        EXT, EXT_BRK: state_nxt = EXT_BRK;
                        default:      state_nxt = BRK;
                    endcase
                end
                default: begin
                    push_req  = 1'b1;
                    push_data = {(state == EXT) || (state == EXT_BRK),
                                 (state == BRK) || (state == EXT_BRK),
                                 rx_dout};
                    state_nxt = IDLE;
                end
`else
                8'hE0: state_nxt = state;   // extended prefix ignored in this build
                8'hF0: state_nxt = BRK;
                default: begin
                    push_req  = 1'b1;
                    push_data = {state == BRK, rx_dout};
                    state_nxt = IDLE;
                end
`endif
            endcase
        end else if (to_hit) begin
            state_nxt = IDLE;
        end
    end

    // Counter only runs while a prefix is pending; any byte restarts it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            to_cnt <= '0;
        end else if (rx_done_tick || state == IDLE) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + CW'(1);
        end
    end

    // ---------------- event FIFO ----------------
    assign full      = (count == DEPTH_C);
    assign key_valid = (count != '0);
    assign pop       = key_valid && key_ready;
    // A pop in the same cycle frees the slot a full FIFO needs.
    assign push      = push_req && (!full || pop);

    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + (AW+1)'(1);
            2'b01:   count_nxt = count - (AW+1)'(1);
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            rx_en    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_nxt;
            rx_en <= (count_nxt < DEPTH_C);
            if (ovf_clr) begin
                overflow <= 1'b0;
            end else if (push_req && !push) begin
                overflow <= 1'b1;
            end
        end
    end

    // Head fields are masked while empty so stale memory never shows.
    assign head      = mem[rd_ptr];
    assign key_code  = key_valid ? head[7:0] : 8'h00;
    assign key_break = key_valid & head[8];
`ifdef PS2_KEY_EXT_EN
    assign key_ext   = key_valid & head[9];
`else
    assign key_ext   = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_key_ctrl.sv
module tb_ps2_key_ctrl;

    localparam int DEPTH = 4;
    localparam int TO    = 40;
`ifdef PS2_KEY_EXT_EN
    localparam logic EXT = 1'b1;
`else
    localparam logic EXT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_done_tick;
    logic [7:0] rx_dout;
    logic       rx_en;
    logic [7:0] key_code;
    logic       key_break;
    logic       key_ext;
    logic       key_valid;
    logic       key_ready;
    logic       overflow;
    logic       ovf_clr;

    ps2_key_ctrl #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TO)) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_done_tick (rx_done_tick),
        .rx_dout      (rx_dout),
        .rx_en        (rx_en),
        .key_code     (key_code),
        .key_break    (key_break),
        .key_ext      (key_ext),
        .key_valid    (key_valid),
        .key_ready    (key_ready),
        .overflow     (overflow),
        .ovf_clr      (ovf_clr)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: queue of {ext,brk,code} events plus pending prefix flags.
    logic [9:0] m_q [$];
    logic       m_ovf, m_rxen, m_ext, m_brk;
    int         since_last;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_ovf = 0; m_rxen = 0; m_ext = 0; m_brk = 0;
        since_last = 0;
    endtask

    task automatic model_step();
        logic       pop, has_ev, take;
        logic [9:0] ev;
        if (!reset) begin
            model_reset();
            return;
        end
        pop    = (m_q.size() > 0) && key_ready;
        has_ev = 0;
        ev     = '0;
        since_last++;
        // a prefix survives while the next byte arrives within TO edges
        if (since_last > TO) begin m_ext = 0; m_brk = 0; end
        if (rx_done_tick) begin
            since_last = 0;
            if (rx_dout == 8'h00 || rx_dout == 8'hFF) begin
                m_ext = 0; m_brk = 0;
            end else if (rx_dout == 8'hE0) begin
                if (EXT) begin m_ext = 1; m_brk = 0; end
            end else if (rx_dout == 8'hF0) begin
                m_brk = 1;
            end else begin
                has_ev = 1;
                ev = {m_ext, m_brk, rx_dout};
                m_ext = 0; m_brk = 0;
            end
        end
        take = has_ev && ((m_q.size() < DEPTH) || pop);
        if (pop) void'(m_q.pop_front());
        if (take) m_q.push_back(ev);
        if (ovf_clr) m_ovf = 0;
        else if (has_ev && !take) m_ovf = 1;
        m_rxen = (m_q.size() < DEPTH);
    endtask

    task automatic check_model();
        logic [9:0] h;
        h = (m_q.size() > 0) ? m_q[0] : 10'h000;
        chk("m_valid", key_valid, m_q.size() > 0);
        chk("m_code",  key_code,  h[7:0]);
        chk("m_break", key_break, h[8]);
        chk("m_ext",   key_ext,   h[9]);
        chk("m_rx_en", rx_en,     m_rxen);
        chk("m_ovf",   overflow,  m_ovf);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check_model();
    endtask

    task automatic send(input logic [7:0] b);
        rx_done_tick = 1'b1;
        rx_dout      = b;
        cycle();
        rx_done_tick = 1'b0;
        rx_dout      = 8'($urandom);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic drain();
        key_ready = 1'b1;
        idle(DEPTH + 1);
        key_ready = 1'b0;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        #1;
        model_reset();
        check_model();
        chk("rst_valid", key_valid, 0);
        chk("rst_code",  key_code,  0);
        chk("rst_break", key_break, 0);
        chk("rst_ext",   key_ext,   0);
        chk("rst_rx_en", rx_en,     0);
        chk("rst_ovf",   overflow,  0);
        idle(2);
        reset = 1'b1;
        cycle();
        chk("rx_en_rise", rx_en, 1);
    endtask

    typedef struct {
        int         n;
        logic [7:0] b0, b1, b2;
        logic       ev;
        logic [7:0] code;
        logic       brk;
        logic       ext;
    } vec_t;

    vec_t vt [9];

    function automatic logic [7:0] pick(input vec_t v, input int j);
        case (j)
            0:       return v.b0;
            1:       return v.b1;
            default: return v.b2;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] ovf_codes [5];
        int         r;

        reset = 1'b0; rx_done_tick = 1'b0; rx_dout = 8'h00;
        key_ready = 1'b0; ovf_clr = 1'b0;
        model_reset();

        vt[0] = '{1, 8'h1C, 8'h00, 8'h00, 1'b1, 8'h1C, 1'b0, 1'b0};
        vt[1] = '{2, 8'hF0, 8'h1C, 8'h00, 1'b1, 8'h1C, 1'b1, 1'b0};
        vt[2] = '{2, 8'hE0, 8'h75, 8'h00, 1'b1, 8'h75, 1'b0, EXT};
        vt[3] = '{3, 8'hE0, 8'hF0, 8'h75, 1'b1, 8'h75, 1'b1, EXT};
        vt[4] = '{2, 8'hF0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
        vt[5] = '{3, 8'hF0, 8'hFF, 8'h1C, 1'b1, 8'h1C, 1'b0, 1'b0};
        vt[6] = '{3, 8'hF0, 8'hE0, 8'h6B, 1'b1, 8'h6B, ~EXT, EXT};
        vt[7] = '{3, 8'hF0, 8'hF0, 8'h12, 1'b1, 8'h12, 1'b1, 1'b0};
        vt[8] = '{3, 8'hE0, 8'h00, 8'h5A, 1'b1, 8'h5A, 1'b0, 1'b0};

        apply_reset();

        // make code with consumer ready: visible one edge later, popped on the next
        key_ready = 1'b1;
        send(8'h1C);
        chk("make_valid", key_valid, 1);
        chk("make_code",  key_code,  8'h1C);
        chk("make_break", key_break, 0);
        chk("make_ext",   key_ext,   0);
        cycle();
        chk("make_popped", key_valid, 0);
        key_ready = 1'b0;

        // decode table
        for (int i = 0; i < 9; i++) begin
            for (int j = 0; j < vt[i].n; j++) begin
                send(pick(vt[i], j));
                if (j < vt[i].n - 1) chk($sformatf("vec%0d_prefix_quiet", i), key_valid, 0);
                idle(1);
            end
            chk($sformatf("vec%0d_valid", i), key_valid, vt[i].ev);
            if (vt[i].ev) begin
                chk($sformatf("vec%0d_code", i),  key_code,  vt[i].code);
                chk($sformatf("vec%0d_break", i), key_break, vt[i].brk);
                chk($sformatf("vec%0d_ext", i),   key_ext,   vt[i].ext);
            end
            drain();
        end

        // timeout: prefix expires after TO quiet cycles
        send(8'hF0);
        idle(TO);
        send(8'h1C);
        chk("to_expired_break", key_break, 0);
        chk("to_expired_code",  key_code,  8'h1C);
        drain();
        // just inside the window the prefix still applies
        send(8'hF0);
        idle(TO - 2);
        send(8'h1C);
        chk("to_live_break", key_break, 1);
        drain();

        // overflow
        ovf_codes = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E};
        for (int i = 0; i < 5; i++) begin
            send(ovf_codes[i]);
            if (i == 3) chk("ovf_rx_en_low", rx_en, 0);
            idle(1);
        end
        chk("ovf_set", overflow, 1);
        key_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("ovf_drain%0d", i), key_code, ovf_codes[i]);
            cycle();
        end
        key_ready = 1'b0;
        chk("ovf_empty", key_valid, 0);
        chk("ovf_sticky", overflow, 1);
        ovf_clr = 1'b1;
        cycle();
        ovf_clr = 1'b0;
        chk("ovf_clr", overflow, 0);

        // reset in the middle of a sequence
        send(8'h1C); idle(1);
        send(8'h32); idle(1);
        send(8'hF0); idle(1);
        chk("pre_rst_valid", key_valid, 1);
        apply_reset();
        send(8'h1C);
        chk("post_rst_valid", key_valid, 1);
        chk("post_rst_break", key_break, 0);
        drain();

        // randomized traffic against the model
        for (int k = 0; k < 1500; k++) begin
            int gap;
            r = $urandom_range(0, 99);
            key_ready = ($urandom_range(0, 99) < 45);
            ovf_clr   = ($urandom_range(0, 99) < 4);
            if (r < 15)      send(8'hF0);
            else if (r < 30) send(8'hE0);
            else if (r < 33) send(8'h00);
            else if (r < 36) send(8'hFF);
            else             send(8'($urandom_range(1, 254)));
            gap = ($urandom_range(0, 99) < 3) ? TO + 3 : $urandom_range(0, 6);
            for (int g = 0; g < gap; g++) begin
                key_ready = ($urandom_range(0, 99) < 45);
                ovf_clr   = ($urandom_range(0, 99) < 4);
                cycle();
            end
        end
        key_ready = 1'b0;
        ovf_clr   = 1'b0;
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
